fx_kport_pad: RTL

Device-side K-port endpoint for the PC-FX: emulates a pad on the console's keypad port. It responds to the host's active-low latch/clock strobes and shifts a 32-bit word LSB-first onto the active-low data line. When the host selects output mode, it captures the 32-bit word the host drives. It sits between the MiSTer input mapping (pad bits) and the KPC port pins, and is used both as the pad model in simulation and as the in-core controller behind the gate array.

---
 rtl/fx_kport_pkg.sv | 16 +
 rtl/fx_kport_sync.sv | 44 ++++
 rtl/fx_kport_pad.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fx_kport_pkg.sv
// Shared types and constants for the PC-FX K-port pad endpoint.
// Holds the transfer FSM state encoding, the default word width and the
// controller ID nibble that a standard pad reports in bits 31:28.
package fx_kport_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } kp_state_e;

    localparam int         KP_BITS_DEF = 32;
    localparam logic [3:0] KP_ID_PAD   = 4'hF;

endpackage

// File: rtl/fx_kport_sync.sv
// N-stage input synchronizer with rise/fall pulses on the synchronized value.
// Latency: STAGES CE cycles to q_o; edge pulses are valid alongside the new q_o.
// No backpressure; pulses are consumed once per CE because the edge history only advances on CE.
//
// Ports: clk_i/res_i/ce_i  clock, sync active-high reset (honoured on CE), clock enable
//        d_i               asynchronous pin input
//        q_o               synchronized level
//        rise_o/fall_o     single-CE pulses on synchronized 0->1 / 1->0 transitions
module fx_kport_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic res_i,
    input  logic ce_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (res_i) begin
                sync_q <= {STAGES{RST_VAL}};
                prev_q <= RST_VAL;
            end else begin
                sync_q[0] <= d_i;
                for (int i = 1; i < STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
                prev_q <= sync_q[STAGES-1];
            end
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  q_o & ~prev_q;
    assign fall_o = ~q_o &  prev_q;

endmodule

// File: rtl/fx_kport_pad.sv
// PC-FX keypad-port device endpoint: shifts PAD_DATA out LSB-first, or captures a host word.
// Latency: pin edge to kp_din_o update is SYNC_STAGES+1 CE cycles.
// No backpressure; the host strobes pace everything, and a latch-low at any time restarts the transfer.
//
// Ports: clk_i/res_i/ce_i   system clock, sync active-high reset (honoured on CE), clock enable
//        kp_latch_i         host latch strobe, active low
//        kp_clk_i           host shift clock, idle high
//        kp_rw_i            1 = host reads pad, 0 = host writes pad
//        kp_dout_i          host->pad data, active low
//        kp_din_o           pad->host data, active low
//        pad_data_i         live pad word (bit 0 first, ID in 31:28)
//        rx_data_o          last complete word received from the host
//        rx_valid_o         one-CE pulse when rx_data_o updates
//        busy_o             high while a transfer is in progress
module fx_kport_pad
    import fx_kport_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int KP_BITS     = KP_BITS_DEF
) (
    input  logic               clk_i,
    input  logic               res_i,
    input  logic               ce_i,
    input  logic               kp_latch_i,
    input  logic               kp_clk_i,
    input  logic               kp_rw_i,
    input  logic               kp_dout_i,
    output logic               kp_din_o,
    input  logic [KP_BITS-1:0] pad_data_i,
    output logic [KP_BITS-1:0] rx_data_o,
    output logic               rx_valid_o,
    output logic               busy_o
);

    localparam int               CW       = $clog2(KP_BITS) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(KP_BITS - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(KP_BITS);

    // Synchronized pins and edge pulses
    logic latch_s, latch_rise, latch_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic rw_s, rw_rise, rw_fall;
    logic dout_s, dout_rise, dout_fall;

    // Idle levels as reset values so no spurious edges appear after reset.
    fx_kport_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_latch (
        .clk_i(clk_i), .res_i(res_i), .ce_i(ce_i), .d_i(kp_latch_i),
        .q_o(latch_s), .rise_o(latch_rise), .fall_o(latch_fall)
    );
    fx_kport_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk_i(clk_i), .res_i(res_i), .ce_i(ce_i), .d_i(kp_clk_i),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    fx_kport_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rw (
        .clk_i(clk_i), .res_i(res_i), .ce_i(ce_i), .d_i(kp_rw_i),
        .q_o(rw_s), .rise_o(rw_rise), .fall_o(rw_fall)
    );
    fx_kport_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dout (
        .clk_i(clk_i), .res_i(res_i), .ce_i(ce_i), .d_i(kp_dout_i),
        .q_o(dout_s), .rise_o(dout_rise), .fall_o(dout_fall)
    );

    // Edge pulses that this endpoint has no use for.
    logic unused_edges;
    assign unused_edges = &{1'b0, latch_fall, sclk_s, rw_rise, rw_fall, dout_rise, dout_fall};

    kp_state_e         state_q, state_d;
    logic [KP_BITS-1:0] sr_q;
    logic [KP_BITS-1:0] rx_q;
    logic [KP_BITS-1:0] rx_data_q;
    logic [CW-1:0]      bitcnt_q;
    logic               dir_q;
    logic               rx_valid_q;

    // Transmit advances after the host has sampled (rising edge);
    // receive captures while the host holds data stable (falling edge).
    logic               shift_evt;
    logic               cnt_adv;
    logic [KP_BITS-1:0] rx_next;

    assign shift_evt = dir_q ? sclk_rise : sclk_fall;
    assign cnt_adv   = (bitcnt_q != CNT_FULL);
    assign rx_next   = {~dout_s, rx_q[KP_BITS-1:1]};

    // State register
    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (res_i) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end
    end

    // Next state: a low latch overrides everything, including a coincident clock edge.
    always_comb begin
        state_d = state_q;
        if (!latch_s) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: if (latch_rise) state_d = XFER;
                XFER: if (shift_evt && bitcnt_q == CNT_LAST) state_d = DONE;
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (res_i) begin
                sr_q       <= '0;
                rx_q       <= '0;
                rx_data_q  <= '0;
                bitcnt_q   <= '0;
                dir_q      <= 1'b1;
                rx_valid_q <= 1'b0;
            end else begin
                rx_valid_q <= 1'b0;
                if (!latch_s) begin
                    // Track the live pad word until the latch releases; an abort
                    // lands here too, so a partial receive never reaches rx_data.
                    sr_q     <= pad_data_i;
                    bitcnt_q <= '0;
                    dir_q    <= rw_s;
                end else if (state_q == XFER && shift_evt && cnt_adv) begin
                    bitcnt_q <= bitcnt_q + 1'b1;
                    if (dir_q) begin
                        sr_q <= {1'b0, sr_q[KP_BITS-1:1]};
                    end else begin
                        rx_q <= rx_next;
                        if (bitcnt_q == CNT_LAST) begin
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Outputs
    always_comb begin
        kp_din_o = 1'b1;
        if ((state_q == LOAD || state_q == XFER) && dir_q) begin
            kp_din_o = ~sr_q[0];
        end
    end

    assign busy_o     = (state_q == XFER);
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule
